// File: rtl/fp_pkg.sv
// fp_pkg: shared types and helpers for the pipelined floating-point multiplier.
//   fp_class_e   - operand classification (ZERO, NORM, INF, NAN)
//   fp_width()   - total word width 1+EXP_W+MAN_W
//   fp_bias()    - exponent bias 2^(EXP_W-1)-1
//   fp_inf_bits()/fp_qnan_bits() - positive infinity and canonical NaN,
//                  right-aligned in 64 bits (callers slice to their width).
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {0, all-ones exponent, zero mantissa}
  function automatic logic [63:0] fp_inf_bits(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return ones << man_w;
  endfunction

  // {0, all-ones exponent, 1 followed by zeros}
  function automatic logic [63:0] fp_qnan_bits(input int exp_w, input int man_w);
    return fp_inf_bits(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// fp_round_norm: combinational normalise/round and rounding-carry fixup.
//   Normalise+round half (stage 2):
//     prod      - (1.ma)x(1.mb), 2*MAN_W+2 bits
//     exp_in    - signed biased exponent sum
//     rnd_carry - rounding carried out of the mantissa
//     rnd_frac  - rounded stored mantissa (wraps to 0 on carry)
//     rnd_exp   - exponent after normalisation
//   Carry fixup half (stage 3):
//     fix_*     - registered stage-2 values
//     out_frac  - final stored mantissa
//     out_exp   - final signed exponent (before range checks)
module fp_round_norm
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]     prod,
  input  logic signed [EXP_W+1:0] exp_in,
  output logic                    rnd_carry,
  output logic [MAN_W-1:0]        rnd_frac,
  output logic signed [EXP_W+1:0] rnd_exp,
  input  logic                    fix_carry,
  input  logic [MAN_W-1:0]        fix_frac,
  input  logic signed [EXP_W+1:0] fix_exp,
  output logic [MAN_W-1:0]        out_frac,
  output logic signed [EXP_W+1:0] out_exp
);

  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] ONE_E  = (EXP_W + 2)'(1);
  localparam logic signed [EXP_W+1:0] ZERO_E = '0;

  logic [MAN_W:0] man;   // kept mantissa including hidden bit
  logic           guard;
  logic           sticky;
  logic           round_up;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    man     = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    rnd_exp = exp_in;
    if (prod[PW-1]) begin
      // Product in [2,4): keep the top bits, bump the exponent.
      man     = prod[PW-1 -: MAN_W+1];
      guard   = prod[PW-2-MAN_W];
      sticky  = |prod[PW-3-MAN_W:0];
      rnd_exp = exp_in + ONE_E;
    end else begin
      // Product in [1,2): the leading one sits one bit lower.
      man    = prod[PW-2 -: MAN_W+1];
      guard  = prod[PW-3-MAN_W];
      sticky = |prod[PW-4-MAN_W:0];
    end
    // Nearest-even: round up above half, or at exactly half when odd.
    round_up  = guard & (sticky | man[0]);
    // Carry out only when the whole 1.fff...f is all ones.
    rnd_carry = round_up & (&man);
    rnd_frac  = man[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, round_up};
  end

  // A rounding carry turns 1.111..1 into 10.000..0: renormalise.
  assign out_frac = fix_carry ? '0 : fix_frac;
  assign out_exp  = fix_exp + (fix_carry ? ONE_E : ZERO_E);

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier with
// valid/ready flow control, round-to-nearest-even and special values.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - operand handshake (op_a, op_b)
//   out_valid/out_ready  - result handshake (result + flags)
//   flag_ovf             - result overflowed to infinity
//   flag_unf             - nonzero result flushed to zero
//   flag_nan             - invalid operation (NaN operand or inf x 0)
// Stage 1: sign, exponent sum, mantissa product, operand classes.
// Stage 2: normalise and round.  Stage 3: carry fixup, range, specials.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 23,
  localparam int W     = fp_width(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_ovf,
  output logic         flag_unf,
  output logic         flag_nan
);

  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W + 2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W + 2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ZERO_E  = '0;
  localparam logic [63:0]  INF64    = fp_inf_bits(EXP_W, MAN_W);
  localparam logic [63:0]  QNAN64   = fp_qnan_bits(EXP_W, MAN_W);
  localparam logic [W-1:0] INF_BITS = INF64[W-1:0];
  localparam logic [W-1:0] QNAN     = QNAN64[W-1:0];

  function automatic fp_class_e classify(input logic [W-1:0] v);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = v[W-2 -: EXP_W];
    m = v[MAN_W-1:0];
    // Denormals (exp==0) are treated as zero.
    if (e == '0)      return ZERO;
    else if (e == '1) return (m == '0) ? INF : NAN;
    else              return NORM;
  endfunction

  // ---------------- handshake ----------------
  logic v1, v2;
  logic en1, en2, en3;

  // A stage loads when the next one is empty or moving; no skid buffer,
  // so in_ready depends combinationally on out_ready.
  assign en3      = !out_valid || out_ready;
  assign en2      = !v2 || en3;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the previous stage's value from before this edge.
      if (en1) v1        <= in_valid;
      if (en2) v2        <= v1;
      if (en3) out_valid <= v2;
    end
  end

  // ---------------- stage 1 ----------------
  logic                    s1_sign_d;
  logic signed [EXP_W+1:0] s1_exp_d;
  logic [PW-1:0]           s1_prod_d;

  always_comb begin
    s1_sign_d = op_a[W-1] ^ op_b[W-1];
    s1_exp_d  = $signed({2'b00, op_a[W-2 -: EXP_W]})
              + $signed({2'b00, op_b[W-2 -: EXP_W]}) - BIAS_S;
    s1_prod_d = {{(MAN_W+1){1'b0}}, 1'b1, op_a[MAN_W-1:0]}
              * {{(MAN_W+1){1'b0}}, 1'b1, op_b[MAN_W-1:0]};
  end

  logic                    s1_sign;
  logic signed [EXP_W+1:0] s1_exp;
  logic [PW-1:0]           s1_prod;
  fp_class_e               s1_cls_a, s1_cls_b;

  // NOTE: datapath registers carry no reset; their contents are only ever
  // consumed under a valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_sign  <= s1_sign_d;
      s1_exp   <= s1_exp_d;
      s1_prod  <= s1_prod_d;
      s1_cls_a <= classify(op_a);
      s1_cls_b <= classify(op_b);
    end
  end

  // ---------------- stage 2 ----------------
  logic                    rnd_carry;
  logic [MAN_W-1:0]        rnd_frac;
  logic signed [EXP_W+1:0] rnd_exp;

  logic                    s2_sign;
  logic                    s2_carry;
  logic [MAN_W-1:0]        s2_frac;
  logic signed [EXP_W+1:0] s2_exp;
  fp_class_e               s2_cls_a, s2_cls_b;

  logic [MAN_W-1:0]        fin_frac;
  logic signed [EXP_W+1:0] fin_exp;

  fp_round_norm #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_norm (
    .prod     (s1_prod),
    .exp_in   (s1_exp),
    .rnd_carry(rnd_carry),
    .rnd_frac (rnd_frac),
    .rnd_exp  (rnd_exp),
    .fix_carry(s2_carry),
    .fix_frac (s2_frac),
    .fix_exp  (s2_exp),
    .out_frac (fin_frac),
    .out_exp  (fin_exp)
  );

  always_ff @(posedge clk) begin
    if (en2 && v1) begin
      s2_sign  <= s1_sign;
      s2_carry <= rnd_carry;
      s2_frac  <= rnd_frac;
      s2_exp   <= rnd_exp;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
    end
  end

  // ---------------- stage 3 ----------------
  logic [W-1:0] s3_result;
  logic         s3_ovf, s3_unf, s3_nan;
  logic         any_nan, any_inf, any_zero;

  always_comb begin
    s3_result = '0;
    s3_ovf    = 1'b0;
    s3_unf    = 1'b0;
    s3_nan    = 1'b0;
    any_nan   = (s2_cls_a == NAN) || (s2_cls_b == NAN);
    any_inf   = (s2_cls_a == INF) || (s2_cls_b == INF);
    any_zero  = (s2_cls_a == ZERO) || (s2_cls_b == ZERO);
    if (any_nan || (any_inf && any_zero)) begin
      s3_result = QNAN;
      s3_nan    = 1'b1;
    end else if (any_inf) begin
      s3_result = {s2_sign, INF_BITS[W-2:0]};
    end else if (any_zero) begin
      s3_result = {s2_sign, {(W-1){1'b0}}};
    end else if (fin_exp >= EXP_MAX) begin
      s3_result = {s2_sign, INF_BITS[W-2:0]};
      s3_ovf    = 1'b1;
    end else if (fin_exp <= ZERO_E) begin
      s3_result = {s2_sign, {(W-1){1'b0}}};
      s3_unf    = 1'b1;
    end else begin
      s3_result = {s2_sign, fin_exp[EXP_W-1:0], fin_frac};
    end
  end

  // Output register only updates on a real load, so result and flags stay
  // put while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_nan <= 1'b0;
    end else if (en3 && v2) begin
      result   <= s3_result;
      flag_ovf <= s3_ovf;
      flag_unf <= s3_unf;
      flag_nan <= s3_nan;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vectors for fp_mult_pipe (default widths).
// The driver pushes hand-computed expectations into a scoreboard queue at
// the cycle an operand pair is accepted; an independent monitor pops and
// compares whenever a result is transferred, and checks hold stability
// while the output is stalled.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_nan;

  always #5 clk = ~clk;

  fp_mult_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_ovf (flag_ovf),
    .flag_unf (flag_unf),
    .flag_nan (flag_nan)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [2:0]  flg;      // {ovf, unf, nan}
    int          acc_cyc;
    bit          lat;      // check 3-cycle latency for this entry
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present a pair and hold it until accepted; record the expectation in
  // the cycle whose closing edge performs the transfer.
  task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [2:0] flg, input bit lat);
    exp_t e;
    bit   done;
    done     = 0;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.name    = name;
        e.res     = res;
        e.flg     = flg;
        e.acc_cyc = cyc;
        e.lat     = lat;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_accept actual=timeout required=accept", name);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain actual=%0d_pending required=0", name, sb.size());
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  bit          pending_new = 1;
  int          first_cyc;
  logic [31:0] held_res;
  logic [2:0]  held_flg;
  exp_t        got;

  always @(negedge clk) begin
    if (rst) begin
      pending_new = 1;
    end else if (out_valid) begin
      if (pending_new) begin
        first_cyc   = cyc;
        held_res    = result;
        held_flg    = {flag_ovf, flag_unf, flag_nan};
        pending_new = 0;
      end else begin
        check("hold_result", result, held_res);
        check("hold_flags", {flag_ovf, flag_unf, flag_nan}, held_flg);
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", result);
        end else begin
          got = sb.pop_front();
          check({got.name, "_result"}, result, got.res);
          check({got.name, "_flags"}, {flag_ovf, flag_unf, flag_nan}, got.flg);
          if (got.lat) check({got.name, "_latency"}, first_cyc - got.acc_cyc, 3);
        end
        pending_new = 1;
      end
    end else begin
      pending_new = 1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", {flag_ovf, flag_unf, flag_nan}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single op into an empty pipe.
    send("mul_2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 1);
    idle();
    wait_drain("basic");

    // Back-to-back directed vectors.
    send("mul_n15x2", 32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000, 1);
    send("rnd_up",    32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000, 1);
    send("rnd_tie",   32'h3F80_0800, 32'h3F80_0800, 32'h3F80_1000, 3'b000, 1);
    send("zero_pos",  32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000, 1);
    send("zero_neg",  32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3'b000, 1);
    send("denorm",    32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 3'b000, 1);
    send("ovf",       32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100, 1);
    send("unf",       32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010, 1);
    send("nan_inf0",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001, 1);
    send("nan_op",    32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b001, 1);
    send("neg_inf",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000, 1);
    send("mul_3x3",   32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 3'b000, 1);
    idle();
    wait_drain("directed");

    // Backpressure: consumer stalled while five pairs are offered.
    out_ready = 1'b0;
    fork
      begin
        send("bp0", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 0);
        send("bp1", 32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000, 0);
        send("bp2", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 0);
        send("bp3", 32'h3F00_0000, 32'h4080_0000, 32'h4000_0000, 3'b000, 0);
        send("bp4", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 3'b000, 0);
        idle();
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted", sb.size(), 3);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("backpressure");

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send("stale0", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000, 0);
    send("stale1", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 3'b000, 0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pre_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_result", result, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_no_stale", out_valid, 0);
    @(posedge clk);
    #1;
    send("post_rst_2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 1);
    idle();
    wait_drain("reset");
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
